fib_bcd_converter: RTL and testbench
====================================

# fib_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the Fibonacci generator. It captures the generator's binary `result` when the generator's `ready` level rises, and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per cycle. It presents packed BCD digits for the display/readout stage, with a one-cycle `done` strobe.

## Interface
- `inBits`, 16, width of the binary input; matches the generator's output width.
- `digits`, 5, number of BCD digits produced. Must satisfy 10^digits > 2^inBits; not checked in RTL.

- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high.
- `start`  input  1  conversion request, level; connects to the generator's `ready`. A conversion triggers only on a 0→1 transition.
- `bin`  input  inBits  binary value to convert; connects to the generator's `result`. Sampled only on the trigger edge.
- `bcd`  output  4*digits  packed BCD result. Digit 0 (units) is in bits [3:0]; digit k is in bits [4k+3:4k].
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  single-cycle pulse when `bcd` has just been updated.

## Operation
- **Reset values:** `bcd`=0, `busy`=0, `done`=0, state IDLE, shift counter 0, start-history register `start_q`=0.
- **Trigger:** `trig = start & ~start_q`. `start_q <= start` every non-reset cycle.
  - Because `start_q` is cleared by reset, a `start` held high across reset release produces exactly one trigger.
  - A level held high produces no further triggers.
- **State machine:**
  - **IDLE:**
    - If `trig`: load the binary shift register with `bin`, clear the BCD scratch register, clear the counter, and go to SHIFT.
    - Otherwise stay in IDLE.
  - **SHIFT:** each cycle, do two steps on the scratch register.
    - First, every scratch nibble ≥5 gets +3 (4-bit, no carry out of the nibble).
    - Then shift {scratch, binary} left by 1 as one concatenated register; the binary MSB enters scratch bit 0.
    - The counter increments each cycle.
    - On the cycle performing shift number inBits (counter == inBits-1): write the post-shift scratch to `bcd`, set `done`=1, and go to IDLE.
- **`busy`** is 1 exactly while the state is SHIFT.
- **`done`** is 1 only in the cycle immediately after the final shift; it clears next cycle.
- **`bcd`** holds its value between conversions. It changes only at completion or reset; intermediate scratch values are never visible.
- **Trigger while busy:** the edge is ignored and lost. `start_q` still tracks `start`, so it does not re-fire later.
- **Trigger in the `done` cycle:** the state is already IDLE, so the trigger is accepted. `done`=1 and `busy`=1 appear back-to-back, with no overlap.
- **Reset mid-conversion:** aborts immediately. All outputs return to reset values, and the partial result is discarded.
- **Values:** `bin`=0 yields all-zero `bcd`. Maximum input 2^inBits-1 is converted exactly; no overflow output exists.
- **Timing independence:** `bin` may change at any time after the trigger edge without affecting the conversion in progress.

## Timing
- Edge E0 samples `trig`=1:
  - `busy`=1 from after E0.
  - Shifts occur at E1..E(inBits); with default inBits=16, the last shift is at E16.
  - At E16: `bcd` is updated, `done`=1, `busy`=0.
  - At E17: `done`=0.
- Latency from trigger edge to valid `bcd`/`done` is inBits cycles.
- Throughput: one conversion per inBits+1 cycles with back-to-back triggers.
- No combinational paths from inputs to outputs; all outputs are registered.

## Test plan
- `bin`=6765 (Fib 20) with `start` rising at E0 and held high:
  - `done` pulses once after E16, with `bcd`=20'h06765.
  - `busy` is high for exactly 16 cycles.
  - No second conversion occurs while `start` stays high.
- Boundary values:
  - `bin`=0 → `bcd`=20'h00000.
  - `bin`=65535 → `bcd`=20'h65535.
  - `bin`=46368 (Fib 24) → `bcd`=20'h46368.
- Second `start` rising edge at E5 of a conversion of 1597:
  - It is ignored; one `done` occurs, with `bcd`=20'h01597.
  - `busy` falls after E16 and does not rise again.
- `reset` asserted for one cycle at E8 of a conversion of 28657:
  - `busy`, `done` and `bcd` go to 0.
  - No `done` occurs afterwards until a new rising edge arrives.
  - A fresh edge with 28657 yields 20'h28657.
- Back-to-back: `start` falls at E3 and rises again in the `done` cycle with `bin`=987.
  - The second conversion is accepted, and `done` pulses 16 cycles later with `bcd`=20'h00987.
  - Between the two pulses, `bcd` holds the first result.
- Drive from the Fibonacci generator with n=10:
  - After its `ready` rises, the converter output is `bcd`=20'h00055 (Fib 10 = 55).

Source files
------------

// File: rtl/fib_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : fib_bcd_converter
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit/cycle,
//            triggered on the rising edge of the Fibonacci generator's ready.
// Revision : 1.0 - initial release
// ============================================================================
module fib_bcd_converter #(
    parameter int inBits = 16,
    parameter int digits = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [inBits-1:0]     bin,
    output logic [4*digits-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int C_CNT_W = $clog2(inBits + 1);
    localparam int C_BCD_W = 4 * digits;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_start_q;
    logic [inBits-1:0]    r_bin;
    logic [inBits-1:0]    w_bin_nxt;
    logic [C_BCD_W-1:0]   r_scratch;
    logic [C_BCD_W-1:0]   w_scratch_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic [C_BCD_W-1:0]   r_bcd;
    logic [C_BCD_W-1:0]   w_bcd_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_trig;
    logic [C_BCD_W-1:0]   w_adj;

    assign w_trig = start & ~r_start_q;

    // Add-3 correction applied to every nibble before the shift.
    generate
        for (genvar k = 0; k < digits; k++) begin : g_adj
            assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5)
                                   ? r_scratch[4*k +: 4] + 4'd3
                                   : r_scratch[4*k +: 4];
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_bin_nxt     = r_bin;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_bin_nxt     = bin;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_scratch_nxt = {w_adj[C_BCD_W-2:0], r_bin[inBits-1]};
                w_bin_nxt     = {r_bin[inBits-2:0], 1'b0};
                w_cnt_nxt     = r_cnt + C_CNT_W'(1);
                if (r_cnt == C_CNT_W'(inBits - 1)) begin
                    w_bcd_nxt   = w_scratch_nxt;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            r_bin     <= w_bin_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bcd     <= w_bcd_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bcd  = r_bcd;
    assign busy = (r_state == S_SHIFT);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fib_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_bcd_converter
// Brief    : Directed self-checking bench for fib_bcd_converter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_bcd_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    int          n_busy, n_done, first_done, second_done, overlap, glitch;
    logic [19:0] last_bcd, bcd_before2, rst_bcd;
    logic        rst_busy, rst_done;

    fib_bcd_converter #(.inBits(16), .digits(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe n post-edge samples (index 0 = just after the trigger edge),
    // applying optional start drop/rise and a one-cycle reset at given indices.
    task automatic watch(input int n, input int drop_at, input int rise_at,
                         input logic [15:0] rise_bin, input int reset_at);
        logic [19:0] prev;
        n_busy = 0; n_done = 0; first_done = -1; second_done = -1;
        overlap = 0; glitch = 0;
        prev = bcd;
        for (int i = 0; i < n; i++) begin
            if (busy) n_busy++;
            if (busy && done) overlap++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
                else begin
                    second_done = i;
                    bcd_before2 = prev;
                end
                last_bcd = bcd;
            end else if (bcd !== prev && i != reset_at + 1) begin
                glitch++;
            end
            if (i == reset_at + 1) begin
                rst_bcd  = bcd;
                rst_busy = busy;
                rst_done = done;
            end
            prev = bcd;
            if (i == drop_at) start = 1'b0;
            if (i == rise_at) begin
                start = 1'b1;
                bin   = rise_bin;
            end
            reset = (i == reset_at);
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic convert(input logic [15:0] val, input logic [19:0] exp, input string tag);
        start = 1'b0;
        tick();
        bin   = val;
        start = 1'b1;
        tick();
        watch(24, -1, -1, 16'h0, -1);
        check_eq({tag, "_bcd"}, bcd, exp);
        check_eq({tag, "_ndone"}, n_done, 1);
    endtask

    initial begin
        int unsigned fa, fb, ft;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = 16'h0;
        repeat (3) tick();
        check_eq("rst_bcd",  bcd,  20'h0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // Fib 20 with start held high.
        bin   = 16'd6765;
        start = 1'b1;
        tick();
        watch(40, -1, -1, 16'h0, -1);
        check_eq("f20_busycyc", n_busy, 16);
        check_eq("f20_ndone",   n_done, 1);
        check_eq("f20_doneidx", first_done, 16);
        check_eq("f20_bcd",     last_bcd, 20'h06765);
        check_eq("f20_glitch",  glitch, 0);

        convert(16'd0,     20'h00000, "zero");
        convert(16'd65535, 20'h65535, "max");
        convert(16'd46368, 20'h46368, "f24");

        // Second edge at E5 is ignored; bin changes mid-conversion.
        start = 1'b0;
        tick();
        bin   = 16'd1597;
        start = 1'b1;
        tick();
        watch(40, 2, 4, 16'h1234, -1);
        check_eq("ign_ndone",   n_done, 1);
        check_eq("ign_bcd",     last_bcd, 20'h01597);
        check_eq("ign_busycyc", n_busy, 16);
        check_eq("ign_busyend", busy, 0);

        // Back-to-back: re-trigger in the done cycle.
        start = 1'b0;
        tick();
        bin   = 16'd6765;
        start = 1'b1;
        tick();
        watch(45, 2, 16, 16'd987, -1);
        check_eq("b2b_ndone",   n_done, 2);
        check_eq("b2b_first",   first_done, 16);
        check_eq("b2b_second",  second_done, 33);
        check_eq("b2b_hold",    bcd_before2, 20'h06765);
        check_eq("b2b_bcd",     last_bcd, 20'h00987);
        check_eq("b2b_overlap", overlap, 0);
        check_eq("b2b_busycyc", n_busy, 32);
        check_eq("b2b_glitch",  glitch, 0);

        // Reset at E8 aborts the conversion.
        start = 1'b0;
        tick();
        bin   = 16'd28657;
        start = 1'b1;
        tick();
        watch(30, 7, -1, 16'h0, 7);
        check_eq("abort_bcd",   rst_bcd, 20'h0);
        check_eq("abort_busy",  rst_busy, 0);
        check_eq("abort_done",  rst_done, 0);
        check_eq("abort_ndone", n_done, 0);
        check_eq("abort_bcd2",  bcd, 20'h0);
        convert(16'd28657, 20'h28657, "f23");

        // Behavioural Fibonacci generator, n = 10.
        start = 1'b0;
        fa = 0;
        fb = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            ft = fa + fb;
            fa = fb;
            fb = ft;
            bin = fa[15:0];
        end
        start = 1'b1;
        tick();
        watch(24, -1, -1, 16'h0, -1);
        check_eq("gen10_bcd",   bcd, 20'h00055);
        check_eq("gen10_ndone", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
